// File: rtl/mips_store_pkg.sv
// mips_store_pkg: shared op encodings, exception codes and FSM states for the store path
package mips_store_pkg;

   typedef enum logic [2:0] {
      ST_SB  = 3'd0,
      ST_SH  = 3'd1,
      ST_SW  = 3'd2,
      ST_SWL = 3'd3,
      ST_SWR = 3'd4
   } st_op_e;

   typedef enum logic [1:0] {
      EXC_NONE    = 2'd0,
      EXC_ADES    = 2'd1,
      EXC_RSVD    = 2'd2,
      EXC_TIMEOUT = 2'd3
   } exc_code_e;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen: maps (op, addr[1:0], data) onto 32-bit byte lanes; SWL/SWR legal only with STORE_UNALIGNED_EN
module store_lane_gen
   import mips_store_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic        o_reserved
);

   // byte enables, replicated/shifted data and legality per store op
   always_comb begin
      o_be         = 4'b0000;
      o_wdata      = 32'h0;
      o_misaligned = 1'b0;
      o_reserved   = 1'b0;
      case (i_op)
         ST_SB: begin
            o_be    = 4'b0001 << i_addr;
            o_wdata = {4{i_data[7:0]}};
         end
         ST_SH: begin
            o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_data[15:0]}};
            o_misaligned = i_addr[0];
         end
         ST_SW: begin
            o_be         = 4'b1111;
            o_wdata      = i_data;
            o_misaligned = |i_addr;
         end
`ifdef STORE_UNALIGNED_EN
         // SWL writes the high-order bytes of rt into the low end of the word
         ST_SWL: begin
            o_be    = 4'b1111 >> (2'd3 - i_addr);
            o_wdata = i_data >> {(2'd3 - i_addr), 3'b000};
         end
         // SWR writes the low-order bytes of rt into the high end of the word
         ST_SWR: begin
            o_be    = 4'b1111 << i_addr;
            o_wdata = i_data << {i_addr, 3'b000};
         end
`endif
         default: o_reserved = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: store request FSM driving a single-outstanding req/ack write port (STORE_UNALIGNED_EN enables SWL/SWR)
module store_align_unit
   import mips_store_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [31:0]           in_data,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   output logic                  exc_valid,
   output logic [1:0]            exc_code,
   output logic [ADDR_WIDTH-1:0] exc_badvaddr,
   output logic                  busy
);

   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

   state_e                r_state;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_baddr;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata;
   logic                  w_mis;
   logic                  w_rsvd;
   logic                  w_ack_cyc;
   logic                  w_accept;
   logic                  w_timeout;

   store_lane_gen u_lane (
      .i_op         (in_op),
      .i_addr       (in_addr[1:0]),
      .i_data       (in_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_mis),
      .o_reserved   (w_rsvd)
   );

   assign w_ack_cyc = (r_state == REQ) & mem_ack;
   assign in_ready  = (r_state == IDLE) | w_ack_cyc;
   assign w_accept  = in_valid & in_ready;
   assign w_timeout = (ACK_TIMEOUT != 0) && (r_state == REQ) && !mem_ack && (r_cnt == CW'(ACK_TIMEOUT - 1));
   assign busy      = (r_state == REQ);

   // accept/ack/timeout sequencing; a new accept in the ack cycle takes priority so stores can stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_baddr      <= '0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
         exc_valid    <= 1'b0;
         exc_code     <= EXC_NONE;
         exc_badvaddr <= '0;
      end else begin
         exc_valid <= 1'b0;
         if (w_accept && !(w_mis || w_rsvd)) begin
            r_state   <= REQ;
            r_cnt     <= '0;
            r_baddr   <= in_addr;
            mem_req   <= 1'b1;
            mem_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
         end else if (w_accept) begin
            r_state      <= IDLE;
            mem_req      <= 1'b0;
            exc_valid    <= 1'b1;
            exc_code     <= w_rsvd ? EXC_RSVD : EXC_ADES;
            exc_badvaddr <= in_addr;
         end else if (w_ack_cyc) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
         end else if (w_timeout) begin
            r_state      <= IDLE;
            mem_req      <= 1'b0;
            exc_valid    <= 1'b1;
            exc_code     <= EXC_TIMEOUT;
            exc_badvaddr <= r_baddr;
         end else if (r_state == REQ) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: directed-vector bench for store_align_unit (expectations follow STORE_UNALIGNED_EN)
module tb_store_align_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        exc_valid;
   logic [1:0]  exc_code;
   logic [31:0] exc_badvaddr;
   logic        busy;
   int          n_total;
   int          n_bad;

   store_align_unit #(.ADDR_WIDTH(32), .ACK_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .mem_ack      (mem_ack),
      .exc_valid    (exc_valid),
      .exc_code     (exc_code),
      .exc_badvaddr (exc_badvaddr),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0;
      in_addr = 32'h0; in_data = 32'h0; mem_ack = 1'b0;
      n_total = 0; n_bad = 0;
      #3;
      check("rst_req", {31'b0, mem_req}, 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_be", {28'b0, mem_be}, 32'h0);
      check("rst_exc", {29'b0, exc_valid, exc_code}, 32'h0);
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      #4 rst_n = 1'b1;
      tick();

      // SB at byte 3, acked on the first REQ cycle
      send(3'd0, 32'h1003, 32'h11223344);
      check("sb_req", {31'b0, mem_req}, 32'd1);
      check("sb_addr", mem_addr, 32'h1000);
      check("sb_be", {28'b0, mem_be}, 32'h8);
      check("sb_wdata", mem_wdata, 32'h44444444);
      check("sb_busy_ready", {30'b0, busy, in_ready}, 32'h2);
      mem_ack = 1'b1;
      #1 check("sb_ready_ack", {31'b0, in_ready}, 32'd1);
      tick();
      mem_ack = 1'b0;
      check("sb_req_drop", {30'b0, mem_req, exc_valid}, 32'h0);

      // SH at 0x2002, ack held off until the 4th REQ cycle (also ack-vs-timeout tie)
      send(3'd1, 32'h2002, 32'hAABBCCDD);
      check("sh_be", {28'b0, mem_be}, 32'hC);
      check("sh_wdata", mem_wdata, 32'hCCDDCCDD);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("sh_hold", {mem_req, in_ready, mem_be, mem_addr[25:0]}, {1'b1, 1'b0, 4'hC, 26'h2000});
         check("sh_hold_wdata", mem_wdata, 32'hCCDDCCDD);
      end
      tick();
      check("sh_c4_req", {31'b0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      #1 check("sh_ready_ack", {31'b0, in_ready}, 32'd1);
      tick();
      mem_ack = 1'b0;
      check("sh_done", {30'b0, mem_req, exc_valid}, 32'h0);

      // misaligned SW, then misaligned SH
      send(3'd2, 32'h3001, 32'h12345678);
      check("sw_mis_exc", {29'b0, mem_req, exc_valid, busy}, 32'h2);
      check("sw_mis_code", {30'b0, exc_code}, 32'd1);
      check("sw_mis_bad", exc_badvaddr, 32'h3001);
      tick();
      check("sw_mis_pulse", {29'b0, exc_valid, exc_code}, 32'h1);
      send(3'd1, 32'h3001, 32'h12345678);
      check("sh_mis_exc", {29'b0, mem_req, exc_valid, busy}, 32'h2);
      check("sh_mis_code", {30'b0, exc_code}, 32'd1);
      check("sh_mis_bad", exc_badvaddr, 32'h3001);

      // back-to-back SW with ack tied high
      mem_ack = 1'b1;
      send(3'd2, 32'h0, 32'hA5A5A5A5);
      in_valid = 1'b1; in_op = 3'd2; in_addr = 32'h4; in_data = 32'h5A5A5A5A;
      check("b2b_first", {mem_req, mem_addr[30:0]}, {1'b1, 31'h0});
      check("b2b_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("b2b_second", {mem_req, mem_addr[30:0]}, {1'b1, 31'h4});
      check("b2b_wdata", mem_wdata, 32'h5A5A5A5A);
      tick();
      check("b2b_drop", {31'b0, mem_req}, 32'd0);
      tick();
      check("idle_ack_ignored", {30'b0, exc_valid, busy}, 32'h0);
      mem_ack = 1'b0;

      // ack timeout after 4 REQ cycles
      send(3'd0, 32'h6001, 32'h000000EE);
      check("to_be", {28'b0, mem_be}, 32'h2);
      tick(); tick(); tick();
      check("to_c4_req", {30'b0, mem_req, exc_valid}, 32'h2);
      tick();
      check("to_drop", {29'b0, mem_req, exc_valid, busy}, 32'h2);
      check("to_code", {30'b0, exc_code}, 32'd3);
      check("to_bad", exc_badvaddr, 32'h6001);
      tick();
      check("to_pulse", {31'b0, exc_valid}, 32'd0);

      // SWL at 0x5001 and a reserved op
      send(3'd3, 32'h5001, 32'h11223344);
`ifdef STORE_UNALIGNED_EN
      check("swl_req", {30'b0, mem_req, exc_valid}, 32'h2);
      check("swl_be", {28'b0, mem_be}, 32'h3);
      check("swl_wdata", mem_wdata, 32'h00001122);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
`else
      check("swl_rsvd", {29'b0, mem_req, exc_valid, busy}, 32'h2);
      check("swl_code", {30'b0, exc_code}, 32'd2);
      check("swl_bad", exc_badvaddr, 32'h5001);
`endif
      send(3'd7, 32'h7004, 32'h0);
      check("op7_code", {29'b0, exc_valid, exc_code}, 32'h6);

      // asynchronous reset mid-REQ
      send(3'd2, 32'h8000, 32'hDEADBEEF);
      check("rstm_req", {31'b0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rstm_drop", {29'b0, mem_req, busy, exc_valid}, 32'h0);
      check("rstm_clr", {mem_addr[29:0], exc_code}, 32'h0);
      #2 rst_n = 1'b1;
      tick();
      check("rstm_idle", {31'b0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
